// File: rtl/sar_dac_pkg.sv
// Shared definitions for the SAR DAC conversion controller: FSM state type,
// default parameter values and the channel-select range helper.
package sar_dac_pkg;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_NCH        = 4;
   localparam int DEF_SAMPLE_CYC = 2;
   localparam int DEF_SETTLE_CYC = 2;

   // Cycle counts are limited to 1..255, so an 8-bit timer covers both phases.
   localparam int TMR_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      CONV   = 2'd2,
      DONE   = 2'd3
   } sar_state_t;

   // Requested channels outside the populated mux range fall back to channel 0.
   function automatic int unsigned map_ch(input int unsigned ch, input int unsigned nch);
      return (ch >= nch) ? 0 : ch;
   endfunction

endpackage

// File: rtl/sar_dac_ctrl_if.sv
// Control, comparator and result signals between the SAR controller (slave)
// and the block that requests conversions and owns the analog front end (master).
interface sar_dac_ctrl_if
   import sar_dac_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NCH   = DEF_NCH
);
   localparam int CW = $clog2(NCH);

   logic             start;
   logic             abort;
   logic             cont;
   logic [CW-1:0]    ch_sel;
   logic             cmp;
   logic [WIDTH-1:0] dac_code;
   logic [CW-1:0]    ch_mux;
   logic             sample_en;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [CW-1:0]    result_ch;

   modport master (
      output start, abort, cont, ch_sel, cmp,
      input  dac_code, ch_mux, sample_en, busy, done, result, result_ch
   );

   modport slave (
      input  start, abort, cont, ch_sel, cmp,
      output dac_code, ch_mux, sample_en, busy, done, result, result_ch
   );

endinterface

// File: rtl/sar_settle_timer.sv
// Loadable down-counter timing both the sample window and each bit trial;
// tc is high while the count sits at zero, i.e. on the last cycle of a phase.
module sar_settle_timer
   import sar_dac_pkg::*;
#(
   parameter int CNT_W = TMR_W
) (
   input  logic             mclk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc
);

   logic [CNT_W-1:0] count;

   // A phase of N cycles is started by loading N-1; the count then parks at zero.
   always_ff @(posedge mclk) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/sar_dac_ctrl.sv
// Successive-approximation ADC controller: sample/hold, MSB-first bit trials, result latch.
// Define SAR_DAC_SCAN_EN to let cont=1 chain conversions across channels without start.
module sar_dac_ctrl
   import sar_dac_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int NCH        = DEF_NCH,
   parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
   input logic           mclk,
   input logic           reset_n,
   sar_dac_ctrl_if.slave bus
);

   localparam int CW = $clog2(NCH);
   localparam int BW = $clog2(WIDTH);

   sar_state_t       state, state_n;
   logic [CW-1:0]    ch_q, ch_next;
   logic [BW-1:0]    bit_idx;
   logic [WIDTH-1:0] code_q, trial_bit, decided;
   logic [WIDTH-1:0] result_q;
   logic [CW-1:0]    result_ch_q;
   logic             accept, scan_next, decide, finish;
   logic             tmr_load, tmr_tc;
   logic [TMR_W-1:0] tmr_val;

   sar_settle_timer #(.CNT_W(TMR_W)) u_timer (
      .mclk     (mclk),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   always_ff @(posedge mclk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // code_q holds only the already-decided upper bits, so OR-ing in the trial
   // bit gives the DAC word with every lower bit still zero.
   always_comb begin
      trial_bit          = '0;
      trial_bit[bit_idx] = 1'b1;
      decided            = bus.cmp ? (code_q | trial_bit) : code_q;
      ch_next            = (ch_q == CW'(NCH - 1)) ? '0 : ch_q + CW'(1);
   end

   // Abort is tested ahead of the timer so it also pre-empts the final bit decision.
   always_comb begin
      state_n   = state;
      accept    = 1'b0;
      scan_next = 1'b0;
      decide    = 1'b0;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_n  = SAMPLE;
               accept   = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(SAMPLE_CYC - 1);
            end
         end
         SAMPLE: begin
            if (bus.abort) begin
               state_n = IDLE;
            end else if (tmr_tc) begin
               state_n  = CONV;
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(SETTLE_CYC - 1);
            end
         end
         CONV: begin
            if (bus.abort) begin
               state_n = IDLE;
            end else if (tmr_tc) begin
               decide = 1'b1;
               if (bit_idx == '0) begin
                  state_n = DONE;
               end else begin
                  tmr_load = 1'b1;
                  tmr_val  = TMR_W'(SETTLE_CYC - 1);
               end
            end
         end
         DONE: begin
`ifdef SAR_DAC_SCAN_EN
            if (bus.cont) begin
               state_n   = SAMPLE;
               scan_next = 1'b1;
               tmr_load  = 1'b1;
               tmr_val   = TMR_W'(SAMPLE_CYC - 1);
            end else begin
               state_n = IDLE;
            end
`else
            state_n = IDLE;
`endif
         end
         default: state_n = IDLE;
      endcase
   end

   assign finish = decide && (bit_idx == '0);

   // The result registers load on the edge into DONE, so the new code is
   // visible exactly while done is high and held until the next completion.
   always_ff @(posedge mclk) begin
      if (!reset_n) begin
         ch_q        <= '0;
         bit_idx     <= '0;
         code_q      <= '0;
         result_q    <= '0;
         result_ch_q <= '0;
      end else begin
         if (accept) begin
            ch_q <= CW'(map_ch(32'(bus.ch_sel), NCH));
         end else if (scan_next) begin
            ch_q <= ch_next;
         end
         if (accept || scan_next) begin
            code_q  <= '0;
            bit_idx <= BW'(WIDTH - 1);
         end else if (decide) begin
            code_q <= decided;
            if (bit_idx != '0) begin
               bit_idx <= bit_idx - BW'(1);
            end
         end
         if (finish) begin
            result_q    <= decided;
            result_ch_q <= ch_q;
         end
      end
   end

`ifndef SAR_DAC_SCAN_EN
   logic unused_cont;
   assign unused_cont = bus.cont;
`endif

   assign bus.dac_code  = (state == CONV) ? (code_q | trial_bit) : '0;
   assign bus.ch_mux    = ch_q;
   assign bus.sample_en = (state == SAMPLE);
   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.result    = result_q;
   assign bus.result_ch = result_ch_q;

endmodule

// File: tb/tb_sar_dac_ctrl.sv
// Scoreboard bench for sar_dac_ctrl: an ideal comparator model per channel,
// expected conversions queued at start and checked whenever done appears.
module tb_sar_dac_ctrl;
   import sar_dac_pkg::*;

   localparam int WIDTH      = 8;
   localparam int NCH        = 4;
   localparam int SAMPLE_CYC = 2;
   localparam int SETTLE_CYC = 2;
   localparam int LAT        = 1 + SAMPLE_CYC + WIDTH * SETTLE_CYC;

   typedef struct {
      int unsigned res;
      int unsigned ch;
      int          cyc;
   } exp_t;

   logic             mclk = 1'b0;
   logic             reset_n;
   int               pcyc = 0;
   int               checks = 0;
   int               errors = 0;
   int unsigned      last_res = 0;
   logic [WIDTH-1:0] vin_tab [NCH];
   exp_t             sb_q[$];

   sar_dac_ctrl_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

   sar_dac_ctrl #(
      .WIDTH      (WIDTH),
      .NCH        (NCH),
      .SAMPLE_CYC (SAMPLE_CYC),
      .SETTLE_CYC (SETTLE_CYC)
   ) dut (
      .mclk    (mclk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 mclk = ~mclk;

   always @(posedge mclk) pcyc <= pcyc + 1;

   // Ideal comparator: each channel carries a fixed input voltage.
   assign bus.cmp = (vin_tab[bus.ch_mux] >= bus.dac_code);

   task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, pcyc);
      end
   endtask

   // A perfect SAR against an ideal comparator converges to the input code itself.
   always @(negedge mclk) begin
      exp_t e;
      if (bus.done === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: done=1 at cycle %0d, required done=0", pcyc);
         end else begin
            e = sb_q.pop_front();
            checkOutput("result", bus.result, e.res);
            checkOutput("result_ch", bus.result_ch, e.ch);
            checkOutput("done_cycle", pcyc, e.cyc);
            last_res = e.res;
         end
      end
   end

   task automatic applyStimulus(input int ch, input int v, input bit track,
                                input bit with_abort, output int p);
      @(negedge mclk);
      vin_tab[ch] = WIDTH'(v);
      bus.ch_sel  = 2'(ch);
      bus.start   = 1'b1;
      bus.abort   = with_abort;
      p = pcyc;
      if (track) sb_q.push_back(exp_t'{res: v, ch: ch, cyc: p + LAT});
      @(negedge mclk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
   endtask

   task automatic waitUntil(input int c);
      while (pcyc < c) @(negedge mclk);
   endtask

   task automatic waitDrain(input int limit);
      int n = 0;
      while (sb_q.size() != 0 && n < limit) begin
         @(negedge mclk);
         n++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: %0d conversions outstanding, required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic checkIdleAfter(input string tag, input int unsigned exp_res);
      checkOutput({tag, "_busy"}, bus.busy, 0);
      checkOutput({tag, "_done"}, bus.done, 0);
      checkOutput({tag, "_dac_code"}, bus.dac_code, 0);
      checkOutput({tag, "_sample_en"}, bus.sample_en, 0);
      checkOutput({tag, "_result"}, bus.result, exp_res);
   endtask

   initial begin
      int p;
      int ch;
      int v;
      reset_n    = 1'b0;
      bus.start  = 1'b0;
      bus.abort  = 1'b0;
      bus.cont   = 1'b0;
      bus.ch_sel = '0;
      for (int i = 0; i < NCH; i++) vin_tab[i] = '0;
      repeat (3) @(negedge mclk);

      checkOutput("rst_dac_code", bus.dac_code, 0);
      checkOutput("rst_ch_mux", bus.ch_mux, 0);
      checkOutput("rst_sample_en", bus.sample_en, 0);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_done", bus.done, 0);
      checkOutput("rst_result", bus.result, 0);
      checkOutput("rst_result_ch", bus.result_ch, 0);
      reset_n = 1'b1;

      applyStimulus(0, 'hA5, 1'b1, 1'b0, p);
      waitDrain(LAT + 10);
      applyStimulus(1, 'h00, 1'b1, 1'b0, p);
      waitDrain(LAT + 10);
      applyStimulus(2, 'hFF, 1'b1, 1'b0, p);
      waitDrain(LAT + 10);

      for (int i = 0; i < 8; i++) begin
         ch = int'($urandom_range(0, NCH - 1));
         v  = int'($urandom_range(0, 255));
         applyStimulus(ch, v, 1'b1, 1'b0, p);
         waitDrain(LAT + 10);
      end

      // Abort in IDLE alongside start must not block the accept.
      applyStimulus(3, 'h5A, 1'b1, 1'b1, p);
      waitDrain(LAT + 10);

      // Abort in the 10th cycle after accept.
      applyStimulus(1, 'h33, 1'b0, 1'b0, p);
      waitUntil(p + 10);
      bus.abort = 1'b1;
      @(negedge mclk);
      bus.abort = 1'b0;
      checkIdleAfter("abort_mid", last_res);
      repeat (LAT + 5) @(negedge mclk);

      // Abort on the last bit decision must still suppress done.
      applyStimulus(2, 'hC3, 1'b0, 1'b0, p);
      waitUntil(p + LAT - 1);
      bus.abort = 1'b1;
      @(negedge mclk);
      bus.abort = 1'b0;
      checkIdleAfter("abort_last", last_res);
      repeat (LAT + 5) @(negedge mclk);

      // Abort during DONE changes nothing.
      applyStimulus(0, 'h81, 1'b1, 1'b0, p);
      waitUntil(p + LAT);
      bus.abort = 1'b1;
      @(negedge mclk);
      bus.abort = 1'b0;
      waitDrain(LAT + 10);

      // start held high: back-to-back conversions one IDLE cycle apart.
      @(negedge mclk);
      vin_tab[2]  = 8'h6E;
      bus.ch_sel  = 2'd2;
      bus.start   = 1'b1;
      p = pcyc;
      sb_q.push_back(exp_t'{res: 'h6E, ch: 2, cyc: p + LAT});
      sb_q.push_back(exp_t'{res: 'h6E, ch: 2, cyc: p + 2 * LAT + 1});
      waitUntil(p + 2 * LAT + 1);
      bus.start = 1'b0;
      waitDrain(10);
      repeat (LAT + 5) @(negedge mclk);

      // Reset in the middle of CONV.
      applyStimulus(3, 'h99, 1'b0, 1'b0, p);
      waitUntil(p + 8);
      reset_n = 1'b0;
      @(negedge mclk);
      checkIdleAfter("rst_mid", 0);
      checkOutput("rst_mid_ch_mux", bus.ch_mux, 0);
      checkOutput("rst_mid_result_ch", bus.result_ch, 0);
      last_res = 0;
      reset_n = 1'b1;
      applyStimulus(1, 'h3C, 1'b1, 1'b0, p);
      waitDrain(LAT + 10);

`ifdef SAR_DAC_SCAN_EN
      // Continuous scan from channel 3 wraps through 0, 1, 2.
      @(negedge mclk);
      for (int i = 0; i < NCH; i++) vin_tab[i] = WIDTH'($urandom_range(0, 255));
      bus.cont   = 1'b1;
      bus.ch_sel = 2'd3;
      bus.start  = 1'b1;
      p = pcyc;
      for (int k = 0; k < NCH; k++) begin
         sb_q.push_back(exp_t'{res: int'(vin_tab[(3 + k) % NCH]), ch: (3 + k) % NCH,
                               cyc: p + LAT * (k + 1)});
      end
      @(negedge mclk);
      bus.start = 1'b0;
      waitUntil(p + 3 * LAT + 3);
      bus.cont = 1'b0;
      waitDrain(2 * LAT);
      repeat (LAT + 5) @(negedge mclk);
`else
      // cont has no effect: one conversion, back to IDLE.
      bus.cont = 1'b1;
      applyStimulus(2, 'h47, 1'b1, 1'b0, p);
      waitDrain(LAT + 10);
      repeat (LAT + 5) @(negedge mclk);
      checkOutput("cont_ignored_busy", bus.busy, 0);
      bus.cont = 1'b0;
`endif

      waitDrain(LAT + 10);
      repeat (3) @(negedge mclk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
